// File: rtl/bg_row_prefetcher.sv
// Background tile-map row prefetcher: pulls one map row into a back bank during
// hblank and serves tile number / in-tile offsets per pixel from the front bank.
module bg_row_prefetcher #(
    parameter int          TILES_X  = 80,
    parameter int          TILE_W   = 10,
    parameter int          TILE_H   = 10,
    parameter logic [29:0] MAP_BASE = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic [15:0] fetch_line,
    input  logic        line_begin,
    input  logic [15:0] pixel,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [15:0] tile_number,
    output logic [7:0]  offset_x,
    output logic [7:0]  offset_y,
    output logic        busy,
    output logic        underrun
);
    localparam int WORDS = TILES_X / 2;
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IW    = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    // EVAL is the one-cycle re-decision after a fetch_start that arrived in READY
    typedef enum logic [1:0] {IDLE, REQ, READY, EVAL} state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [15:0]   line_q, row_q, pend_line_q, active_line_q, active_row_q;
    logic          skip_q, pend_q, act_q, mem_req_q, busy_q, underrun_q;
    logic [1:0]    valid_q;
    logic [29:0]   mem_addr_q;
    logic [15:0]   bank_q [2][TILES_X];
    logic [15:0]   tile_number_q, tile_number_d;
    logic [7:0]    offset_x_q, offset_x_d, offset_y_q, offset_y_d;

    logic [15:0]   start_row, pend_row, eval_row, eval_line;
    logic          eval_go, eval_hit;

    function automatic logic [29:0] word_addr(input logic [15:0] row, input logic [KW-1:0] k);
        return MAP_BASE + 30'(row) * 30'(WORDS) + 30'(k);
    endfunction

    assign start_row = fetch_line / 16'(TILE_H);
    assign pend_row  = pend_line_q / 16'(TILE_H);

    always_comb begin
        eval_go   = 1'b0;
        eval_row  = row_q;
        eval_line = line_q;
        if (state_q == IDLE && fetch_start) begin
            eval_go   = 1'b1;
            eval_row  = start_row;
            eval_line = fetch_line;
        end else if (state_q == EVAL && !fetch_start) begin
            eval_go   = 1'b1;
        end
    end

    assign eval_hit = valid_q[act_q] && (active_row_q == eval_row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            line_q        <= '0;
            row_q         <= '0;
            pend_line_q   <= '0;
            active_line_q <= '0;
            active_row_q  <= '0;
            skip_q        <= 1'b0;
            pend_q        <= 1'b0;
            act_q         <= 1'b0;
            valid_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, EVAL: begin
                    if (line_begin) active_line_q <= line_q;
                    if (state_q == EVAL && fetch_start) begin
                        line_q <= fetch_line;
                        row_q  <= start_row;
                    end else if (eval_go) begin
                        line_q <= eval_line;
                        row_q  <= eval_row;
                        if (eval_hit) begin
                            state_q <= READY;
                            skip_q  <= 1'b1;
                        end else begin
                            state_q          <= REQ;
                            skip_q           <= 1'b0;
                            k_q              <= '0;
                            mem_req_q        <= 1'b1;
                            mem_addr_q       <= word_addr(eval_row, '0);
                            busy_q           <= 1'b1;
                            valid_q[!act_q]  <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (line_begin) begin
                        underrun_q    <= 1'b1;
                        active_line_q <= line_q;
                    end
                    if (fetch_start) begin
                        pend_q      <= 1'b1;
                        pend_line_q <= fetch_line;
                    end
                    if (mem_ack) begin
                        if (pend_q || fetch_start) begin
                            // restart in place; mem_req never drops
                            pend_q     <= 1'b0;
                            k_q        <= '0;
                            line_q     <= fetch_start ? fetch_line : pend_line_q;
                            row_q      <= fetch_start ? start_row : pend_row;
                            mem_addr_q <= word_addr(fetch_start ? start_row : pend_row, '0);
                        end else if (k_q == K_LAST) begin
                            state_q         <= READY;
                            mem_req_q       <= 1'b0;
                            busy_q          <= 1'b0;
                            valid_q[!act_q] <= 1'b1;
                        end else begin
                            k_q        <= k_q + 1'b1;
                            mem_addr_q <= word_addr(row_q, k_q + 1'b1);
                        end
                    end
                end
                READY: begin
                    if (line_begin) begin
                        active_line_q <= line_q;
                        if (!skip_q) begin
                            act_q        <= !act_q;
                            active_row_q <= row_q;
                        end
                    end
                    if (fetch_start) begin
                        line_q  <= fetch_line;
                        row_q   <= start_row;
                        state_q <= EVAL;
                    end else if (line_begin) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == REQ && mem_ack) begin
            bank_q[!act_q][IW'({k_q, 1'b0})] <= mem_data[31:16];
            bank_q[!act_q][IW'({k_q, 1'b1})] <= mem_data[15:0];
        end
    end

    always_comb begin
        tile_number_d = '0;
        if (valid_q[act_q] && ({16'd0, pixel} < 32'(TILES_X * TILE_W)))
            tile_number_d = bank_q[act_q][IW'(pixel / 16'(TILE_W))];
        offset_x_d = 8'(pixel % 16'(TILE_W));
        offset_y_d = 8'(active_line_q % 16'(TILE_H));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_number_q <= '0;
            offset_x_q    <= '0;
            offset_y_q    <= '0;
        end else begin
            tile_number_q <= tile_number_d;
            offset_x_q    <= offset_x_d;
            offset_y_q    <= offset_y_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;
    assign tile_number = tile_number_q;
    assign offset_x    = offset_x_q;
    assign offset_y    = offset_y_q;
endmodule

// File: tb/tb_bg_row_prefetcher.sv
// Self-checking bench for bg_row_prefetcher: directed scenarios plus randomized
// fetch/display sequences against a map-level reference model.
module tb_bg_row_prefetcher;
    localparam int          TX   = 80;
    localparam int          TW   = 10;
    localparam int          TH   = 10;
    localparam logic [29:0] BASE = 30'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic [15:0] fetch_line = '0;
    logic        line_begin = 1'b0;
    logic [15:0] pixel = '0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic [15:0] tile_number;
    logic [7:0]  offset_x, offset_y;
    logic        busy, underrun;

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_mode = 0;
    int          ack_cnt = 0;
    logic [31:0] salt = '0;
    logic [29:0] acks[$];
    bit          m_valid;
    int          m_row, m_line;

    bg_row_prefetcher #(.TILES_X(TX), .TILE_W(TW), .TILE_H(TH), .MAP_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .fetch_line(fetch_line),
        .line_begin(line_begin), .pixel(pixel), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .tile_number(tile_number),
        .offset_x(offset_x), .offset_y(offset_y), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // VRAM contents: a salted function of the word address
    function automatic logic [31:0] vram(input logic [29:0] a);
        return {a[15:0] ^ salt[15:0], a[15:0] ^ salt[31:16] ^ 16'h5a5a};
    endfunction

    // tile the display should show for pixel p given the model's active row
    function automatic logic [15:0] exp_tile(input int p);
        logic [31:0] w;
        if (!m_valid || p >= TX * TW) return 16'h0;
        w = vram(BASE + 30'(m_row * (TX / 2) + p / (2 * TW)));
        return ((p / TW) % 2 == 0) ? w[31:16] : w[15:0];
    endfunction

    task automatic step();
        if (mem_req && mem_ack) acks.push_back(mem_addr);
        @(posedge clk);
        #1;
        mem_data = vram(mem_addr);
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: begin ack_cnt++; mem_ack = (ack_cnt % 3 == 0); end
            2: mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = 1'b0;
        endcase
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; fetch_start = 1'b0; line_begin = 1'b0; pixel = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_valid = 0; m_row = 0; m_line = 0;
        acks.delete();
    endtask

    task automatic pulse_fetch(input int line);
        fetch_line = 16'(line); fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
    endtask

    task automatic pulse_line_begin();
        line_begin = 1'b1;
        step();
        line_begin = 1'b0;
    endtask

    task automatic test_reset();
        int hi;
        apply_reset();
        ack_mode = 3; step();
        pulse_fetch(35);
        step();
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL reset_pre_req: mem_req=%b want 1", mem_req); end
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_vec++; if (mem_addr !== 30'h0) begin n_err++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        n_vec++; if (busy !== 1'b0 || underrun !== 1'b0) begin n_err++; $display("FAIL reset_flags: busy=%b underrun=%b want 0 0", busy, underrun); end
        n_vec++; if (tile_number !== 16'h0 || offset_x !== 8'h0 || offset_y !== 8'h0) begin
            n_err++; $display("FAIL reset_pixel: tile=%0h ox=%0d oy=%0d want 0 0 0", tile_number, offset_x, offset_y);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        m_valid = 0; m_row = 0; m_line = 0;
        ack_mode = 0; pixel = 16'd37; hi = 0;
        for (int i = 0; i < 10; i++) begin step(); if (mem_req) hi++; end
        n_vec++; if (hi != 0) begin n_err++; $display("FAIL idle_quiet: mem_req high %0d cycles want 0", hi); end
        n_vec++; if (tile_number !== exp_tile(37) || offset_x !== 8'd7 || offset_y !== 8'd0) begin
            n_err++; $display("FAIL idle_pixel: tile=%0h ox=%0d oy=%0d want %0h 7 0", tile_number, offset_x, offset_y, exp_tile(37));
        end
    endtask

    task automatic test_basic_fetch();
        int cnt, bad;
        logic [31:0] w;
        apply_reset();
        ack_mode = 0; step();
        acks.delete();
        pulse_fetch(35);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== BASE + 30'd120) begin
            n_err++; $display("FAIL basic_first_req: req=%b addr=%0d want 1 120", mem_req, mem_addr);
        end
        cnt = 0;
        while (busy && cnt < 100) begin cnt++; step(); end
        n_vec++; if (cnt != 40) begin n_err++; $display("FAIL basic_busy_len: %0d cycles want 40", cnt); end
        bad = (acks.size() != 40);
        if (!bad) foreach (acks[i]) if (acks[i] !== BASE + 30'(120 + i)) bad = 1;
        n_vec++; if (bad) begin n_err++; $display("FAIL basic_addrs: %0d words accepted, want 40 at 120..159", acks.size()); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop: mem_req=%b want 0", mem_req); end
        pulse_line_begin();
        m_valid = 1; m_row = 3; m_line = 35;
        pixel = 16'd25; step();
        w = vram(BASE + 30'd121);
        n_vec++; if (tile_number !== w[31:16]) begin n_err++; $display("FAIL basic_tile25: got %0h want %0h", tile_number, w[31:16]); end
        n_vec++; if (offset_x !== 8'd5 || offset_y !== 8'd5) begin n_err++; $display("FAIL basic_offsets: ox=%0d oy=%0d want 5 5", offset_x, offset_y); end
    endtask

    task automatic test_wait_states();
        int cyc, unstable, bad, p;
        logic p_req, p_ack;
        logic [29:0] p_addr;
        logic [31:0] w;
        apply_reset();
        ack_mode = 1; ack_cnt = 0; step();
        acks.delete();
        pulse_fetch(35);
        cyc = 0; unstable = 0;
        while (busy && cyc < 300) begin
            p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
            step(); cyc++;
            if (p_req && !p_ack && (mem_req !== 1'b1 || mem_addr !== p_addr)) unstable++;
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ws_timeout: busy=%b after %0d cycles want 0", busy, cyc); end
        n_vec++; if (unstable != 0) begin n_err++; $display("FAIL ws_stable: %0d unstable cycles want 0", unstable); end
        bad = (acks.size() != 40);
        if (!bad) foreach (acks[i]) if (acks[i] !== BASE + 30'(120 + i)) bad = 1;
        n_vec++; if (bad) begin n_err++; $display("FAIL ws_addrs: %0d words accepted, want 40 at 120..159", acks.size()); end
        pulse_line_begin();
        m_valid = 1; m_row = 3; m_line = 35;
        pixel = 16'd795; step();
        w = vram(BASE + 30'd159);
        n_vec++; if (tile_number !== w[15:0] || offset_x !== 8'd5) begin
            n_err++; $display("FAIL ws_tile795: tile=%0h ox=%0d want %0h 5", tile_number, offset_x, w[15:0]);
        end
        for (int j = 0; j < 4; j++) begin
            p = $urandom_range(0, TX * TW - 1);
            pixel = 16'(p); step();
            n_vec++; if (tile_number !== exp_tile(p)) begin n_err++; $display("FAIL ws_tile_rand: pixel %0d got %0h want %0h", p, tile_number, exp_tile(p)); end
        end
    endtask

    task automatic test_same_row_skip();
        int p;
        ack_mode = 0; step();
        acks.delete();
        pulse_fetch(36);
        n_vec++; if (busy !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL skip_nofetch: busy=%b req=%b want 0 0", busy, mem_req); end
        step(); step();
        n_vec++; if (acks.size() != 0) begin n_err++; $display("FAIL skip_acks: %0d words accepted want 0", acks.size()); end
        pulse_line_begin();
        m_line = 36;
        p = $urandom_range(0, TX * TW - 1);
        pixel = 16'(p); step();
        n_vec++; if (tile_number !== exp_tile(p) || offset_y !== 8'd6) begin
            n_err++; $display("FAIL skip_display: pixel %0d tile=%0h oy=%0d want %0h 6", p, tile_number, offset_y, exp_tile(p));
        end
    endtask

    task automatic test_underrun();
        int cyc, bad, p;
        apply_reset();
        ack_mode = 0; step();
        pulse_fetch(35);
        cyc = 0; while (busy && cyc < 100) begin step(); cyc++; end
        pulse_line_begin();
        m_valid = 1; m_row = 3; m_line = 35;
        n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_clean: underrun=%b want 0", underrun); end
        acks.delete();
        pulse_fetch(57);
        repeat (10) step();
        pulse_line_begin();
        m_line = 57;
        n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_set: underrun=%b want 1", underrun); end
        p = $urandom_range(0, TX * TW - 1);
        pixel = 16'(p); step();
        n_vec++; if (tile_number !== exp_tile(p) || offset_y !== 8'd7) begin
            n_err++; $display("FAIL ur_old_row: pixel %0d tile=%0h oy=%0d want %0h 7", p, tile_number, offset_y, exp_tile(p));
        end
        cyc = 0; while (busy && cyc < 100) begin step(); cyc++; end
        bad = (busy !== 1'b0) || (acks.size() != 40);
        if (!bad) foreach (acks[i]) if (acks[i] !== BASE + 30'(200 + i)) bad = 1;
        n_vec++; if (bad) begin n_err++; $display("FAIL ur_complete: %0d words accepted busy=%b, want 40 at 200..239", acks.size(), busy); end
        n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_sticky: underrun=%b want 1", underrun); end
        pulse_line_begin();
        m_row = 5; m_line = 57;
        p = $urandom_range(0, TX * TW - 1);
        pixel = 16'(p); step();
        n_vec++; if (tile_number !== exp_tile(p)) begin n_err++; $display("FAIL ur_new_row: pixel %0d got %0h want %0h", p, tile_number, exp_tile(p)); end
    endtask

    task automatic test_restart();
        logic [29:0] exp_q[$];
        int cyc, gap, bad, p;
        ack_mode = 1; ack_cnt = 0; step();
        acks.delete();
        pulse_fetch(75);
        cyc = 0; while (acks.size() < 5 && cyc < 100) begin step(); cyc++; end
        n_vec++; if (acks.size() != 5) begin n_err++; $display("FAIL rs_progress: %0d words accepted want 5", acks.size()); end
        pulse_fetch(40);
        cyc = 0; gap = 0;
        while (busy && cyc < 400) begin if (!mem_req) gap++; step(); cyc++; end
        for (int k = 0; k < 6; k++) exp_q.push_back(BASE + 30'(280 + k));
        for (int k = 0; k < 40; k++) exp_q.push_back(BASE + 30'(160 + k));
        bad = (busy !== 1'b0) || (acks.size() != exp_q.size());
        if (!bad) foreach (exp_q[i]) if (acks[i] !== exp_q[i]) bad = 1;
        n_vec++; if (bad) begin n_err++; $display("FAIL rs_addrs: %0d words accepted busy=%b, want 280..285 then 160..199", acks.size(), busy); end
        n_vec++; if (gap != 0) begin n_err++; $display("FAIL rs_req_gap: mem_req low %0d busy cycles want 0", gap); end
        pulse_line_begin();
        m_row = 4; m_line = 40;
        p = $urandom_range(0, TX * TW - 1);
        pixel = 16'(p); step();
        n_vec++; if (tile_number !== exp_tile(p) || offset_y !== 8'd0) begin
            n_err++; $display("FAIL rs_display: pixel %0d tile=%0h oy=%0d want %0h 0", p, tile_number, offset_y, exp_tile(p));
        end
    endtask

    task automatic test_out_of_range();
        int pix[4];
        pix = '{800, 65535, 799, 0};
        foreach (pix[i]) begin
            pixel = 16'(pix[i]); step();
            n_vec++; if (tile_number !== exp_tile(pix[i]) || offset_x !== 8'(pix[i] % TW)) begin
                n_err++; $display("FAIL oor_pixel%0d: tile=%0h ox=%0d want %0h %0d", pix[i], tile_number, offset_x, exp_tile(pix[i]), pix[i] % TW);
            end
        end
    endtask

    task automatic test_random();
        logic [29:0] exp_q[$];
        int line, row, cur_line, cur_row, cyc, p, bad;
        bit pend_lb, skip;
        apply_reset();
        ack_mode = 2; step();
        pend_lb = 0; cur_line = 0; cur_row = 0;
        for (int it = 0; it < 25; it++) begin
            if (it > 0 && $urandom_range(0, 3) == 0) line = cur_row * TH + int'($urandom_range(0, TH - 1));
            else line = int'($urandom_range(0, 299));
            row = line / TH;
            if (pend_lb) begin m_valid = 1; m_row = cur_row; m_line = cur_line; end
            skip = m_valid && (m_row == row);
            exp_q.delete();
            if (!skip) for (int k = 0; k < TX / 2; k++) exp_q.push_back(BASE + 30'(row * (TX / 2) + k));
            acks.delete();
            fetch_line = 16'(line); fetch_start = 1'b1; line_begin = pend_lb;
            step();
            fetch_start = 1'b0; line_begin = 1'b0;
            step();
            cyc = 0; while (busy && cyc < 400) begin step(); cyc++; end
            bad = (busy !== 1'b0) || (acks.size() != exp_q.size());
            if (!bad) foreach (exp_q[i]) if (acks[i] !== exp_q[i]) bad = 1;
            n_vec++; if (bad) begin
                n_err++; $display("FAIL rand_fetch%0d: line %0d got %0d words busy=%b, want %0d words", it, line, acks.size(), busy, exp_q.size());
            end
            cur_line = line; cur_row = row;
            if ($urandom_range(0, 1) == 1) begin
                pulse_line_begin();
                pend_lb = 0;
                m_valid = 1; m_row = cur_row; m_line = cur_line;
                for (int j = 0; j < 3; j++) begin
                    p = int'($urandom_range(0, TX * TW + 30));
                    pixel = 16'(p); step();
                    n_vec++; if (tile_number !== exp_tile(p) || offset_x !== 8'(p % TW) || offset_y !== 8'(m_line % TH)) begin
                        n_err++; $display("FAIL rand_pixel%0d: pixel %0d tile=%0h ox=%0d oy=%0d want %0h %0d %0d",
                                          it, p, tile_number, offset_x, offset_y, exp_tile(p), p % TW, m_line % TH);
                    end
                end
            end else begin
                pend_lb = 1;
            end
        end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_same_row_skip();
        test_underrun();
        test_restart();
        test_out_of_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bg_row_prefetcher.md
Name: bg_row_prefetcher

Overview:
- Sequences tile-map fetches for the background layer.
- During horizontal blanking it reads one full tile-map row (TILES_X 16-bit entries, packed two per 32-bit word) from shared VRAM into a double-buffered row cache.
- During the active line it serves tile_number, offset_x and offset_y per pixel from the active buffer, so the background path does no per-pixel memory reads.
- Sits between the video timing generator and the VRAM arbiter port.

Parameters:
- TILES_X, 80, tiles per map row; must be even.
- TILE_W, 10, tile width in pixels.
- TILE_H, 10, tile height in lines.
- MAP_BASE, 30'h0, word address of tile-map row 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_start  in  1  single-cycle pulse: begin prefetch for fetch_line.
- fetch_line  in  16  line to be displayed next; sampled on fetch_start.
- line_begin  in  1  single-cycle pulse: the line last requested by fetch_start begins now.
- pixel  in  16  current pixel x.
- mem_req  out  1  VRAM read request.
- mem_addr  out  30  VRAM word address.
- mem_ack  in  1  read accepted; mem_data is valid in the same cycle.
- mem_data  in  32  read data; [31:16] is the even tile, [15:0] the odd tile.
- tile_number  out  16  tile index for pixel, registered.
- offset_x  out  8  pixel % TILE_W, registered.
- offset_y  out  8  active line % TILE_H, registered.
- busy  out  1  fetch in progress.
- underrun  out  1  sticky flag; cleared only by reset.

Behaviour:
- **Reset** (async, rst_n=0):
  - Outputs: mem_req, mem_addr, tile_number, offset_x, offset_y, busy and underrun all 0.
  - State: FSM in IDLE; both bank valid bits cleared; active_line = 0; active_row = 0.
- **Row/address arithmetic:**
  - row = fetch_line / TILE_H.
  - Word k (0..TILES_X/2-1) is at MAP_BASE + row*(TILES_X/2) + k, computed modulo 2^30.
  - Word k writes back-bank entry 2k from mem_data[31:16] and entry 2k+1 from mem_data[15:0].
- **FSM:**
  - IDLE:
    - On fetch_start, latch fetch_line and row.
    - If the active bank is valid and active_row == row, go to READY with skip=1 and make no memory access.
    - Otherwise go to REQ with k=0 and skip=0.
  - REQ:
    - mem_req=1, mem_addr = address of word k, busy=1.
    - mem_req and mem_addr are held stable until mem_ack.
    - On mem_ack, write both entries.
    - If k == TILES_X/2-1, go to READY and drop mem_req the next cycle; otherwise k++ and stay in REQ. Back-to-back acks give one word per cycle.
  - READY:
    - busy=0; back bank valid (or skip).
    - On line_begin: if skip=0, swap banks and set active_row = fetched row. In both cases set active_line = latched fetch_line, then go to IDLE.
- **line_begin outside READY:**
  - In REQ: set underrun=1, update active_line, do not swap (the old row keeps displaying), and continue the fetch.
  - In IDLE: update active_line only.
- **fetch_start in REQ:**
  - Latched as pending with its line.
  - The outstanding handshake completes; at that ack the FSM restarts at k=0 for the pending row. The back bank is not marked valid.
  - mem_req stays high across the restart.
- **fetch_start in READY:** overwrites the latched line and re-evaluates exactly as from IDLE in the next cycle.
- **Same-cycle fetch_start and line_begin in READY:** line_begin is processed first (swap), then fetch_start is evaluated against the new active_row.
- **Pixel path** (1-cycle latency, every cycle):
  - If the active bank is invalid or pixel >= TILES_X*TILE_W: tile_number = 0.
  - Otherwise tile_number = active[pixel / TILE_W].
  - offset_x = pixel % TILE_W; offset_y = active_line % TILE_H.
- **Width rules:** divisions and remainders are unsigned; offsets are truncated to 8 bits.

Test Plan:
- **Reset/idle:** assert rst_n=0 mid-cycle with mem_req high → all outputs 0 immediately. Release, then hold with no pulses → mem_req stays 0.
- **Basic fetch:** fetch_line=35 with mem_ack tied 1 → 40 consecutive requests at addresses 120..159, busy high for 40 cycles, then READY. After line_begin, pixel=25 returns mem_data[31:16] of word 121 one cycle later, with offset_x=5 and offset_y=5.
- **Wait states:** ack every 3rd cycle → mem_addr stable while unacked, and exactly 40 acked words are written. Check pixel=795 → odd entry of word 159.
- **Same-row skip:** after row 3 is active, fetch_line=36 → no mem_req, READY in 1 cycle; line_begin gives no swap and offset_y=6.
- **Underrun and restart:**
  - line_begin at word 10 → underrun=1, old row still displayed, fetch completes.
  - A second fetch_start (line 40) at word 5 → after the pending ack, addresses restart at 160.
- **Out of range:** pixel=800 → tile_number=0.
